// File: rtl/filtro_biquad_multicanal_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : filtro_pkg
//  Description : Shared types and helpers for the multichannel biquad filter:
//                FSM state encoding, coefficient select codes, accumulator
//                and channel-index width functions.
//  Revision    : 1.0  initial release
// ============================================================================
package filtro_pkg;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2
    } estado_t;

    // Coefficient select codes, also used as MAC tap indices
    localparam logic [2:0] COEF_B0 = 3'd0;
    localparam logic [2:0] COEF_B1 = 3'd1;
    localparam logic [2:0] COEF_B2 = 3'd2;
    localparam logic [2:0] COEF_A1 = 3'd3;
    localparam logic [2:0] COEF_A2 = 3'd4;

    // Five 2N-bit products need 3 guard bits to never overflow
    function automatic int ACC_W(input int n);
        return 2 * n + 3;
    endfunction

    // Channel index width, never narrower than one bit
    function automatic int CANAL_W(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/filtro_biquad_multicanal_mac.sv
`default_nettype none
// ============================================================================
//  Module      : filtro_mac
//  Description : Signed NxN multiplier feeding an accumulator with
//                synchronous clear, enable and add/subtract select.
//  Ports       : clk, rst     clock, synchronous active-high reset
//                i_clr        clear accumulator (priority over i_en)
//                i_en         accumulate one product
//                i_sub        1: subtract product, 0: add product
//                i_a, i_b     signed operands (N bits)
//                o_acc        signed accumulator (ACC_W(N) bits)
//  Revision    : 1.0  initial release
// ============================================================================
module filtro_mac
    import filtro_pkg::*;
#(
    parameter int N = 25
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clr,
    input  logic                        i_en,
    input  logic                        i_sub,
    input  logic signed [N-1:0]         i_a,
    input  logic signed [N-1:0]         i_b,
    output logic signed [ACC_W(N)-1:0]  o_acc
);

    localparam int AW = ACC_W(N);

    logic signed [2*N-1:0] w_prod;
    logic signed [AW-1:0]  w_prod_ext;
    logic signed [AW-1:0]  r_acc;

    assign w_prod     = i_a * i_b;
    assign w_prod_ext = {{(AW-2*N){w_prod[2*N-1]}}, w_prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/filtro_biquad_multicanal.sv
`default_nettype none
// ============================================================================
//  Module      : filtro_biquad_multicanal
//  Description : Direct Form I biquad, CH channels with private history and
//                shared run-time coefficients, one time-multiplexed MAC.
//                y = (b0*u + b1*u1 + b2*u2 - a1*y1 - a2*y2) >>> F, limited
//                to N bits. Build option FILTRO_SATURACION_EN selects
//                clamping; otherwise the result wraps to its low N bits.
//  Ports       : Clk, Reset              clock, synchronous active-high reset
//                Uk, In_Canal            input sample and its channel
//                Bandera_ADC, In_Ready   input strobe / block idle
//                Coef_We, Coef_Sel,      coefficient write port
//                Coef_Dato               (0=b0 1=b1 2=b2 3=a1 4=a2)
//                Yk, Out_Canal           filtered sample and its channel
//                Bandera_Listo           one-cycle output valid pulse
//  Revision    : 1.0  initial release
// ============================================================================
module filtro_biquad_multicanal
    import filtro_pkg::*;
#(
    parameter int N  = 25,
    parameter int F  = 16,
    parameter int CH = 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [N-1:0]            Uk,
    input  logic [CANAL_W(CH)-1:0]  In_Canal,
    input  logic                    Bandera_ADC,
    output logic                    In_Ready,
    input  logic                    Coef_We,
    input  logic [2:0]              Coef_Sel,
    input  logic [N-1:0]            Coef_Dato,
    output logic [N-1:0]            Yk,
    output logic [CANAL_W(CH)-1:0]  Out_Canal,
    output logic                    Bandera_Listo
);

    localparam int AW = ACC_W(N);
    localparam int CW = CANAL_W(CH);

    estado_t                r_estado;
    estado_t                w_estado_sig;
    logic [2:0]             r_tap;
    logic signed [N-1:0]    r_u;
    logic [CW-1:0]          r_canal;

    logic signed [N-1:0]    r_b0, r_b1, r_b2, r_a1, r_a2;

    logic signed [N-1:0]    r_u1 [CH];
    logic signed [N-1:0]    r_u2 [CH];
    logic signed [N-1:0]    r_y1 [CH];
    logic signed [N-1:0]    r_y2 [CH];

    logic [N-1:0]           r_yk;
    logic [CW-1:0]          r_out_canal;
    logic                   r_listo;

    logic                   w_canal_ok;
    logic [CW-1:0]          w_idx;
    logic signed [N-1:0]    w_h_u1, w_h_u2, w_h_y1, w_h_y2;
    logic signed [N-1:0]    w_op_coef, w_op_dato;
    logic                   w_sub;
    logic                   w_mac_clr, w_mac_en;
    logic signed [AW-1:0]   w_acc;
    logic signed [N-1:0]    w_lim;

    // Out-of-range channels are filtered against a zero history and never
    // write back, so the array is only ever indexed in range.
    assign w_canal_ok = (32'(r_canal) < CH);
    assign w_idx      = w_canal_ok ? r_canal : '0;
    assign w_h_u1     = w_canal_ok ? r_u1[w_idx] : '0;
    assign w_h_u2     = w_canal_ok ? r_u2[w_idx] : '0;
    assign w_h_y1     = w_canal_ok ? r_y1[w_idx] : '0;
    assign w_h_y2     = w_canal_ok ? r_y2[w_idx] : '0;

    // Tap operand selection; feedback terms are subtracted
    always_comb begin
        w_op_coef = r_b0;
        w_op_dato = r_u;
        w_sub     = 1'b0;
        case (r_tap)
            COEF_B0: begin w_op_coef = r_b0; w_op_dato = r_u;                 end
            COEF_B1: begin w_op_coef = r_b1; w_op_dato = w_h_u1;              end
            COEF_B2: begin w_op_coef = r_b2; w_op_dato = w_h_u2;              end
            COEF_A1: begin w_op_coef = r_a1; w_op_dato = w_h_y1; w_sub = 1'b1; end
            default: begin w_op_coef = r_a2; w_op_dato = w_h_y2; w_sub = 1'b1; end
        endcase
    end

    // Next-state and MAC control
    always_comb begin
        w_estado_sig = r_estado;
        w_mac_clr    = 1'b0;
        w_mac_en     = 1'b0;
        case (r_estado)
            IDLE: begin
                if (Bandera_ADC) begin
                    w_mac_clr    = 1'b1;
                    w_estado_sig = MAC;
                end
            end
            MAC: begin
                w_mac_en = 1'b1;
                if (r_tap == COEF_A2) begin
                    w_estado_sig = WB;
                end
            end
            WB: begin
                w_estado_sig = IDLE;
            end
            default: begin
                w_estado_sig = IDLE;
            end
        endcase
    end

    filtro_mac #(
        .N (N)
    ) u_mac (
        .clk   (Clk),
        .rst   (Reset),
        .i_clr (w_mac_clr),
        .i_en  (w_mac_en),
        .i_sub (w_sub),
        .i_a   (w_op_coef),
        .i_b   (w_op_dato),
        .o_acc (w_acc)
    );

    // Arithmetic shift floors toward -inf before limiting to N bits
`ifdef FILTRO_SATURACION_EN
    logic signed [AW-1:0] w_esc;
    assign w_esc = w_acc >>> F;
    always_comb begin
        w_lim = w_esc[N-1:0];
        // Fits only when every bit from N-1 upward equals the sign
        if (!((&w_esc[AW-1:N-1]) || !(|w_esc[AW-1:N-1]))) begin
            w_lim = w_esc[AW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end
`else
    assign w_lim = N'(w_acc >>> F);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_estado    <= IDLE;
            r_tap       <= '0;
            r_u         <= '0;
            r_canal     <= '0;
            r_b0        <= '0;
            r_b1        <= '0;
            r_b2        <= '0;
            r_a1        <= '0;
            r_a2        <= '0;
            r_yk        <= '0;
            r_out_canal <= '0;
            r_listo     <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                r_u1[i] <= '0;
                r_u2[i] <= '0;
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else begin
            r_estado <= w_estado_sig;
            r_listo  <= 1'b0;
            case (r_estado)
                IDLE: begin
                    // Coefficients only change between computations
                    if (Coef_We) begin
                        case (Coef_Sel)
                            COEF_B0: r_b0 <= Coef_Dato;
                            COEF_B1: r_b1 <= Coef_Dato;
                            COEF_B2: r_b2 <= Coef_Dato;
                            COEF_A1: r_a1 <= Coef_Dato;
                            COEF_A2: r_a2 <= Coef_Dato;
                            default: ;
                        endcase
                    end
                    if (Bandera_ADC) begin
                        r_u     <= Uk;
                        r_canal <= In_Canal;
                        r_tap   <= '0;
                    end
                end
                MAC: begin
                    r_tap <= r_tap + 3'd1;
                end
                WB: begin
                    if (w_canal_ok) begin
                        r_yk         <= w_lim;
                        r_out_canal  <= r_canal;
                        r_listo      <= 1'b1;
                        r_u2[w_idx]  <= w_h_u1;
                        r_u1[w_idx]  <= r_u;
                        r_y2[w_idx]  <= w_h_y1;
                        r_y1[w_idx]  <= w_lim;
                    end
                end
                default: ;
            endcase
        end
    end

    assign In_Ready      = (r_estado == IDLE);
    assign Yk            = r_yk;
    assign Out_Canal     = r_out_canal;
    assign Bandera_Listo = r_listo;

endmodule
`default_nettype wire

// File: tb/tb_filtro_biquad_multicanal.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_filtro_biquad_multicanal
//  Description : Self-checking bench for filtro_biquad_multicanal (CH=3 so
//                that an out-of-range channel code exists). Directed cases
//                plus randomized samples against an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_filtro_biquad_multicanal;
    import filtro_pkg::*;

    localparam int N  = 25;
    localparam int F  = 16;
    localparam int CH = 3;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic [N-1:0] Uk = '0;
    logic [1:0]   In_Canal = '0;
    logic         Bandera_ADC = 1'b0;
    logic         In_Ready;
    logic         Coef_We = 1'b0;
    logic [2:0]   Coef_Sel = '0;
    logic [N-1:0] Coef_Dato = '0;
    logic [N-1:0] Yk;
    logic [1:0]   Out_Canal;
    logic         Bandera_Listo;

    filtro_biquad_multicanal #(.N(N), .F(F), .CH(CH)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Uk            (Uk),
        .In_Canal      (In_Canal),
        .Bandera_ADC   (Bandera_ADC),
        .In_Ready      (In_Ready),
        .Coef_We       (Coef_We),
        .Coef_Sel      (Coef_Sel),
        .Coef_Dato     (Coef_Dato),
        .Yk            (Yk),
        .Out_Canal     (Out_Canal),
        .Bandera_Listo (Bandera_Listo)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    longint mb [5];
    longint mu1 [CH];
    longint mu2 [CH];
    longint my1 [CH];
    longint my2 [CH];
    logic signed [63:0] last_y;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 5; i++) mb[i] = 0;
        for (int i = 0; i < CH; i++) begin
            mu1[i] = 0; mu2[i] = 0; my1[i] = 0; my2[i] = 0;
        end
    endfunction

    function automatic longint limit(input longint s);
        longint lo, hi, m, w;
        lo = -(longint'(1) << (N-1));
        hi = (longint'(1) << (N-1)) - 1;
        m  = longint'(1) << N;
`ifdef FILTRO_SATURACION_EN
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
`else
        w = s & (m - 1);
        if (w > hi) w = w - m;
        if (lo > w) w = lo;   // unreachable guard keeps lo referenced
        return w;
`endif
    endfunction

    function automatic longint model(input longint u, input int ch);
        longint h_u1, h_u2, h_y1, h_y2, acc, y;
        h_u1 = 0; h_u2 = 0; h_y1 = 0; h_y2 = 0;
        if (ch < CH) begin
            h_u1 = mu1[ch]; h_u2 = mu2[ch]; h_y1 = my1[ch]; h_y2 = my2[ch];
        end
        acc = mb[0]*u + mb[1]*h_u1 + mb[2]*h_u2 - mb[3]*h_y1 - mb[4]*h_y2;
        y = limit(acc >>> F);
        if (ch < CH) begin
            mu2[ch] = h_u1; mu1[ch] = u; my2[ch] = h_y1; my1[ch] = y;
        end
        return y;
    endfunction

    function automatic longint rnd(input int half);
        return longint'($urandom_range(0, 2*half)) - longint'(half);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Bandera_ADC = 1'b0; Coef_We = 1'b0;
        tick();
        Reset = 1'b0;
        model_clear();
    endtask

    task automatic write_coef(input int sel, input longint val);
        Coef_We = 1'b1; Coef_Sel = sel[2:0]; Coef_Dato = val[N-1:0];
        tick();
        Coef_We = 1'b0;
        if (sel < 5) mb[sel] = val;
    endtask

    // mode 0 plain, 1 extra strobe while busy, 2 coef write while busy,
    // 3 coef b0 write in the same cycle as the accept
    task automatic send(input longint u, input int ch, input int mode, input longint cval);
        longint exp;
        longint junk;
        int     n;
        bit     seen;
        chk("ready_before", In_Ready, 1);
        if (mode == 3) begin
            mb[0] = cval;
            Coef_We = 1'b1; Coef_Sel = COEF_B0; Coef_Dato = cval[N-1:0];
        end
        exp = model(u, ch);
        Uk = u[N-1:0]; In_Canal = ch[1:0]; Bandera_ADC = 1'b1;
        tick();
        Bandera_ADC = 1'b0; Coef_We = 1'b0;
        n = 1;
        chk("busy", In_Ready, 0);
        if (mode == 1) begin
            junk = rnd(100000);
            Uk = junk[N-1:0]; Bandera_ADC = 1'b1;
            tick(); n++;
            Bandera_ADC = 1'b0;
        end else if (mode == 2) begin
            junk = rnd(200000);
            Coef_We = 1'b1; Coef_Sel = COEF_B0; Coef_Dato = junk[N-1:0];
            tick(); n++;
            Coef_We = 1'b0;
        end
        seen = 1'b0;
        while (n < 12 && !seen) begin
            if (Bandera_Listo === 1'b1) seen = 1'b1;
            else begin tick(); n++; end
        end
        if (ch < CH) begin
            chk("latency", seen ? n : -1, 7);
            chk("yk", $signed(Yk), exp);
            chk("out_canal", Out_Canal, ch);
            chk("ready_with_listo", In_Ready, 1);
            last_y = $signed(Yk);
        end else begin
            chk("invalid_ch_no_listo", seen, 0);
            last_y = 'x;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint y;
        bit     seen;

        // Reset state
        model_clear();
        tick(); tick();
        chk("rst_yk", $signed(Yk), 0);
        chk("rst_listo", Bandera_Listo, 0);
        chk("rst_out_canal", Out_Canal, 0);
        Reset = 1'b0;
        tick();
        chk("rst_ready", In_Ready, 1);

        // Identity
        write_coef(COEF_B0, 65536);
        send(1000, 0, 0, 0);
        chk("identity", last_y, 1000);

        // FIR impulse
        do_reset();
        write_coef(COEF_B0, 16384);
        write_coef(COEF_B1, 16384);
        write_coef(COEF_B2, 16384);
        send(4000, 1, 0, 0); chk("fir0", last_y, 1000);
        send(0,    1, 0, 0); chk("fir1", last_y, 1000);
        send(0,    1, 0, 0); chk("fir2", last_y, 1000);
        send(0,    1, 0, 0); chk("fir3", last_y, 0);

        // a1 recursion
        do_reset();
        write_coef(COEF_B0, 65536);
        write_coef(COEF_A1, -32768);
        send(1024, 0, 0, 0); chk("a1_0", last_y, 1024);
        send(0,    0, 0, 0); chk("a1_1", last_y, 512);
        send(0,    0, 0, 0); chk("a1_2", last_y, 256);
        send(0,    0, 0, 0); chk("a1_3", last_y, 128);

        // a2 recursion
        do_reset();
        write_coef(COEF_B0, 65536);
        write_coef(COEF_A2, -32768);
        send(1024, 2, 0, 0); chk("a2_0", last_y, 1024);
        send(0,    2, 0, 0); chk("a2_1", last_y, 0);
        send(0,    2, 0, 0); chk("a2_2", last_y, 512);
        send(0,    2, 0, 0); chk("a2_3", last_y, 0);
        send(0,    2, 0, 0); chk("a2_4", last_y, 256);

        // Channel independence and invalid channel guard
        do_reset();
        write_coef(COEF_B0, 65536);
        write_coef(COEF_A1, -32768);
        send(1024, 0, 0, 0); chk("ind_c0_0", last_y, 1024);
        send(0,    1, 0, 0); chk("ind_c1_0", last_y, 0);
        send(0,    0, 0, 0); chk("ind_c0_1", last_y, 512);
        send(0,    1, 0, 0); chk("ind_c1_1", last_y, 0);
        send(777,  3, 0, 0);
        send(0,    0, 0, 0); chk("ind_c0_2", last_y, 256);

        // Overflow
        do_reset();
        write_coef(COEF_B0, 131072);
        send(16777215, 0, 0, 0);
`ifdef FILTRO_SATURACION_EN
        chk("overflow", last_y, 16777215);
`else
        chk("overflow", last_y, -2);
`endif

        // Control corners: write while busy, strobe while busy, same-cycle write
        do_reset();
        write_coef(COEF_B0, 65536);
        send(1000, 0, 2, 0); chk("we_busy", last_y, 1000);
        send(500,  0, 0, 0); chk("we_busy_after", last_y, 500);
        send(700,  0, 1, 0); chk("drop_busy", last_y, 700);
        send(1000, 0, 3, 131072); chk("we_with_adc", last_y, 2000);

        // Reset during MAC at tap 2
        do_reset();
        write_coef(COEF_B0, 65536);
        write_coef(COEF_A1, -32768);
        send(1024, 0, 0, 0);
        Uk = 25'd1000; In_Canal = 2'd0; Bandera_ADC = 1'b1;
        tick();
        Bandera_ADC = 1'b0;
        tick(); tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        model_clear();
        seen = 1'b0;
        repeat (10) begin
            if (Bandera_Listo === 1'b1) seen = 1'b1;
            tick();
        end
        chk("rst_mid_no_listo", seen, 0);
        chk("rst_mid_yk", $signed(Yk), 0);
        send(1000, 0, 0, 0); chk("rst_mid_zero_coef", last_y, 0);
        write_coef(COEF_B0, 65536);
        send(1000, 0, 0, 0); chk("rst_mid_rewrite", last_y, 1000);

        // Randomized traffic
        do_reset();
        write_coef(COEF_B0, rnd(131072));
        write_coef(COEF_B1, rnd(131072));
        write_coef(COEF_B2, rnd(131072));
        write_coef(COEF_A1, rnd(40000));
        write_coef(COEF_A2, rnd(20000));
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                write_coef(int'($urandom_range(0, 7)), rnd(131072));
            end
            y = rnd(1 << 20);
            send(y, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rnd(131072));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
